// File: rtl/ustc_out_collector.sv
// ustc_out_collector: packs sparse valid lanes of the array bus into a FIFO and drains dense OUT_LANES beats.
// Optional USTC_COLLECT_ZERO_SKIP_EN drops zero-valued lanes and counts them in zero_cnt.
module ustc_out_collector #(
   parameter int N_BUSLINE  = 62,
   parameter int DW_DATA    = 32,
   parameter int OUT_LANES  = 4,
   parameter int FIFO_DEPTH = 128
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [N_BUSLINE*DW_DATA-1:0]       in_bus,
   input  logic [N_BUSLINE-1:0]               in_valid,
   input  logic                               flush_req,
   output logic                               stall,
   output logic [OUT_LANES*DW_DATA-1:0]       out_data,
   output logic [$clog2(OUT_LANES):0]         out_count,
   output logic                               out_last,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [$clog2(FIFO_DEPTH):0]        level,
   output logic                               err_ovf,
   output logic [15:0]                        zero_cnt
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(OUT_LANES) + 1;

   typedef enum logic {RUN, FLUSH} state_t;

   state_t             state_q, state_d;
   logic [DW_DATA-1:0] mem_q [FIFO_DEPTH];
   logic [DW_DATA-1:0] mem_d [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, idx;
   logic [LW-1:0]      level_q, level_d, free, p, pop_n;
   logic               stall_q, stall_d, err_q, err_d, push, fire;
   logic [15:0]        zero_cnt_q, zero_cnt_d;
   logic [N_BUSLINE-1:0] wen;
   logic [CW-1:0]      cnt;

   always_comb begin
      wen = '0;
      p = '0;
      for (int i = 0; i < N_BUSLINE; i++) begin
`ifdef USTC_COLLECT_ZERO_SKIP_EN
         wen[i] = in_valid[i] && (in_bus[i*DW_DATA +: DW_DATA] != '0);
`else
         wen[i] = in_valid[i];
`endif
         p = p + LW'(wen[i]);
      end
   end

   always_comb begin
      free      = LW'(FIFO_DEPTH) - level_q;
      out_valid = (state_q == FLUSH) || (level_q >= LW'(OUT_LANES));
      cnt       = (state_q == RUN) ? CW'(OUT_LANES) :
                  (level_q < LW'(OUT_LANES)) ? CW'(level_q) : CW'(OUT_LANES);
      out_count = out_valid ? cnt : '0;
      out_last  = (state_q == FLUSH) && (level_q <= LW'(OUT_LANES));
      out_data  = '0;
      for (int k = 0; k < OUT_LANES; k++)
         out_data[k*DW_DATA +: DW_DATA] = (CW'(k) < out_count) ? mem_q[rd_ptr_q + AW'(k)] : '0;
   end

   // Whole-beat acceptance only; the pop of the same cycle does not free space for it.
   always_comb begin
      push     = (state_q == RUN) && (p <= free);
      fire     = out_valid && out_ready;
      pop_n    = fire ? LW'(out_count) : '0;
      level_d  = level_q + (push ? p : '0) - pop_n;
      rd_ptr_d = rd_ptr_q + AW'(pop_n);
      stall_d  = (LW'(FIFO_DEPTH) - level_d) < LW'(N_BUSLINE);
      err_d    = err_q || ((state_q == RUN) && (p > free)) || ((state_q == FLUSH) && (|in_valid));
      mem_d    = mem_q;
      idx      = wr_ptr_q;
      for (int i = 0; i < N_BUSLINE; i++)
         if (push && wen[i]) begin
            mem_d[idx] = in_bus[i*DW_DATA +: DW_DATA];
            idx = idx + 1'b1;
         end
      wr_ptr_d = idx;
      state_d  = (state_q == RUN) ? (flush_req ? FLUSH : RUN) : ((fire && out_last) ? RUN : FLUSH);
   end

`ifdef USTC_COLLECT_ZERO_SKIP_EN
   logic [LW-1:0] z;
   logic [16:0]   zsum;
   always_comb begin
      z = '0;
      for (int i = 0; i < N_BUSLINE; i++) z = z + LW'(in_valid[i] && !wen[i]);
      zsum       = 17'(zero_cnt_q) + (push ? 17'(z) : 17'd0);
      zero_cnt_d = zsum[16] ? 16'hFFFF : zsum[15:0];
   end
`else
   always_comb zero_cnt_d = '0;
`endif

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (reset) begin
         state_q    <= RUN;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         stall_q    <= 1'b0;
         err_q      <= 1'b0;
         zero_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         stall_q    <= stall_d;
         err_q      <= err_d;
         zero_cnt_q <= zero_cnt_d;
      end
   end

   assign stall    = stall_q;
   assign level    = level_q;
   assign err_ovf  = err_q;
   assign zero_cnt = zero_cnt_q;
endmodule

// File: tb/tb_ustc_out_collector.sv
// tb_ustc_out_collector: table-driven directed vectors plus short hand sequences for ustc_out_collector.
module tb_ustc_out_collector;
   logic           clk = 1'b0;
   logic           reset, flush_req, out_ready;
   logic [1983:0]  in_bus;
   logic [61:0]    in_valid;
   logic           stall, out_last, out_valid, err_ovf;
   logic [127:0]   out_data;
   logic [2:0]     out_count;
   logic [7:0]     level;
   logic [15:0]    zero_cnt;
   int             nvec = 0, nfail = 0;

   ustc_out_collector dut (
      .clk(clk), .reset(reset), .in_bus(in_bus), .in_valid(in_valid), .flush_req(flush_req),
      .stall(stall), .out_data(out_data), .out_count(out_count), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready), .level(level), .err_ovf(err_ovf),
      .zero_cnt(zero_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rst; logic [61:0] v; logic [31:0] b; logic fl; logic rdy;
      logic [7:0] lvl; logic ov; logic [2:0] cnt; logic last; logic stl; logic err; logic [127:0] dat;
   } vec_t;

   localparam logic [61:0] ALL = {62{1'b1}};
   localparam logic [61:0] L3  = 62'h2000_0000_0000_0021;

   function automatic logic [1983:0] build(input logic [61:0] v, input logic [31:0] b);
      logic [31:0] r = b;
      build = '0;
      for (int i = 0; i < 62; i++)
         if (v[i]) begin
            build[i*32 +: 32] = r;
            r++;
         end else build[i*32 +: 32] = 32'hDEAD_0000 + 32'(i);
   endfunction

   function automatic logic [127:0] d4(input logic [31:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   function automatic vec_t mk(input logic r, input logic [61:0] v, input logic [31:0] b, input logic f, rd,
                               input logic [7:0] l, input logic ov, input logic [2:0] c, input logic la, st, er,
                               input logic [127:0] dt);
      vec_t x;
      x.rst = r; x.v = v; x.b = b; x.fl = f; x.rdy = rd;
      x.lvl = l; x.ov = ov; x.cnt = c; x.last = la; x.stl = st; x.err = er; x.dat = dt;
      return x;
   endfunction

   task automatic apply(input logic r, input logic [61:0] v, input logic [31:0] b, input logic f, rd);
      reset = r; in_valid = v; in_bus = build(v, b); flush_req = f; out_ready = rd;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
      nvec++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   vec_t tv[30];
   logic [7:0] nb;

   initial begin
      tv[0]  = mk(1, 0,       0, 0, 0,   0, 0, 0, 0, 0, 0, '0);
      tv[1]  = mk(0, L3,      1, 0, 0,   3, 0, 0, 0, 0, 0, '0);
      tv[2]  = mk(0, 0,       0, 0, 0,   3, 0, 0, 0, 0, 0, '0);
      tv[3]  = mk(0, 0,       0, 1, 0,   3, 1, 3, 1, 0, 0, d4(1, 2, 3, 0));
      tv[4]  = mk(0, 0,       0, 0, 0,   3, 1, 3, 1, 0, 0, d4(1, 2, 3, 0));
      tv[5]  = mk(0, 0,       0, 0, 1,   0, 0, 0, 0, 0, 0, '0);
      tv[6]  = mk(0, 62'hF,   1, 0, 1,   4, 1, 4, 0, 0, 0, d4(1, 2, 3, 4));
      tv[7]  = mk(0, 62'hF,   5, 0, 1,   4, 1, 4, 0, 0, 0, d4(5, 6, 7, 8));
      tv[8]  = mk(0, 62'hF,   9, 0, 1,   4, 1, 4, 0, 0, 0, d4(9, 10, 11, 12));
      tv[9]  = mk(0, 0,       0, 0, 1,   0, 0, 0, 0, 0, 0, '0);
      tv[10] = mk(0, 62'hF,   1, 0, 0,   4, 1, 4, 0, 0, 0, d4(1, 2, 3, 4));
      tv[11] = mk(0, 62'hF,   5, 0, 0,   8, 1, 4, 0, 0, 0, d4(1, 2, 3, 4));
      tv[12] = mk(0, 62'hF,   9, 0, 1,   8, 1, 4, 0, 0, 0, d4(5, 6, 7, 8));
      tv[13] = mk(0, 0,       0, 0, 1,   4, 1, 4, 0, 0, 0, d4(9, 10, 11, 12));
      tv[14] = mk(0, 0,       0, 0, 1,   0, 0, 0, 0, 0, 0, '0);
      tv[15] = mk(0, 0,       0, 1, 0,   0, 1, 0, 1, 0, 0, '0);
      tv[16] = mk(0, 62'hF,   1, 0, 0,   0, 1, 0, 1, 0, 1, '0);
      tv[17] = mk(0, 0,       0, 0, 1,   0, 0, 0, 0, 0, 1, '0);
      tv[18] = mk(1, 0,       0, 0, 0,   0, 0, 0, 0, 0, 0, '0);
      tv[19] = mk(0, ALL,     1, 0, 0,  62, 1, 4, 0, 0, 0, d4(1, 2, 3, 4));
      tv[20] = mk(0, ALL,     1, 0, 0, 124, 1, 4, 0, 1, 0, d4(1, 2, 3, 4));
      tv[21] = mk(0, ALL,     1, 0, 0, 124, 1, 4, 0, 1, 1, d4(1, 2, 3, 4));
      tv[22] = mk(0, 0,       0, 1, 1, 120, 1, 4, 0, 1, 1, d4(5, 6, 7, 8));
      tv[23] = mk(1, 0,       0, 0, 0,   0, 0, 0, 0, 0, 0, '0);
      tv[24] = mk(0, 62'h1F,  1, 0, 0,   5, 1, 4, 0, 0, 0, d4(1, 2, 3, 4));
      tv[25] = mk(0, 0,       0, 1, 0,   5, 1, 4, 0, 0, 0, d4(1, 2, 3, 4));
      tv[26] = mk(0, 0,       0, 0, 1,   1, 1, 1, 1, 0, 0, d4(5, 0, 0, 0));
      tv[27] = mk(0, 0,       0, 0, 1,   0, 0, 0, 0, 0, 0, '0);
      tv[28] = mk(0, 62'h1,   1, 1, 1,   1, 1, 1, 1, 0, 0, d4(1, 0, 0, 0));
      tv[29] = mk(0, 0,       0, 0, 1,   0, 0, 0, 0, 0, 0, '0);

      for (int i = 0; i < 30; i++) begin
         apply(tv[i].rst, tv[i].v, tv[i].b, tv[i].fl, tv[i].rdy);
         chk($sformatf("vec%0d", i),
             {17'd0, level, out_valid, out_count, out_last, stall, err_ovf, out_data},
             {17'd0, tv[i].lvl, tv[i].ov, tv[i].cnt, tv[i].last, tv[i].stl, tv[i].err, tv[i].dat});
      end

      // Stall must rise after exactly two full-width beats, then the next beat is dropped.
      apply(1, 0, 0, 0, 0);
      nb = 0;
      while (!stall && nb < 4) begin
         apply(0, ALL, 1, 0, 0);
         nb++;
      end
      chk("stall_rise", 160'({nb, level, stall, err_ovf}), 160'({8'd2, 8'd124, 1'b1, 1'b0}));
      apply(0, ALL, 100, 0, 0);
      chk("drop_full", 160'({level, err_ovf, out_data}), 160'({8'd124, 1'b1, d4(1, 2, 3, 4)}));

      // A second flush_req while draining must not prolong the flush.
      apply(1, 0, 0, 0, 0);
      apply(0, 62'h1F, 1, 0, 0);
      apply(0, 0, 0, 1, 0);
      apply(0, 0, 0, 1, 1);
      chk("flush_in_flush", 160'({level, out_valid, out_count, out_last}), 160'({8'd1, 1'b1, 3'd1, 1'b1}));
      apply(0, 0, 0, 1, 1);
      chk("flush_exit", 160'({level, out_valid, out_count, out_last}), 160'({8'd0, 1'b0, 3'd0, 1'b0}));
      apply(0, 0, 0, 0, 1);
      chk("run_idle", 160'({level, out_valid, err_ovf}), 160'({8'd0, 1'b0, 1'b0}));

      // Zero-valued lanes: skipped only when the zero-skip build is selected.
      apply(1, 0, 0, 0, 0);
      reset = 1'b0; in_valid = 62'h7; in_bus = '0; in_bus[63:32] = 32'd7; flush_req = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      #1;
`ifdef USTC_COLLECT_ZERO_SKIP_EN
      chk("zero_skip", 160'({level, zero_cnt}), 160'({8'd1, 16'd2}));
`else
      chk("zero_skip", 160'({level, zero_cnt}), 160'({8'd3, 16'd0}));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
